// File: rtl/phys_reg_free_list.sv
// Free list of physical register indices for rename.
// Circular FIFO: rename retires a whole ALLOC_W head window per pop, and unconsumed lanes are recycled to the tail.
module phys_reg_free_list #(
   parameter  int unsigned NUM_PHYS_REGS = 16,
   parameter  int unsigned ALLOC_W       = 4,
   parameter  int unsigned FREE_W        = 2,
   parameter  int unsigned RESERVED      = 4,
   localparam int unsigned PW            = $clog2(NUM_PHYS_REGS),
   localparam int unsigned CW            = PW + 1
) (
   input  logic                          clk,
   input  logic                          rst_in,
   output logic [ALLOC_W-1:0][PW-1:0]    free_register_data,
   output logic                          frl_valid,
   input  logic [ALLOC_W-1:0]            frl_ready,
   input  logic [FREE_W-1:0]             free_valid,
   input  logic [FREE_W-1:0][PW-1:0]     free_idx,
   output logic [CW-1:0]                 free_count,
   output logic                          err_underflow,
   output logic                          err_overflow
);

   localparam int unsigned     INIT_CNT  = NUM_PHYS_REGS - RESERVED;
   localparam logic [PW-1:0]   INIT_TAIL = PW'(INIT_CNT % NUM_PHYS_REGS);

   logic [PW-1:0] mem_q [NUM_PHYS_REGS];
   logic [PW-1:0] mem_d [NUM_PHYS_REGS];
   logic [PW-1:0] head_q, head_d;
   logic [PW-1:0] tail_q, tail_d;
   logic [CW-1:0] count_q, count_d;
   logic          frl_valid_q, frl_valid_d;
   logic          err_uf_q, err_uf_d;
   logic          err_of_q, err_of_d;

   logic          pop;
   logic [CW-1:0] occ;
   int unsigned   slot;

   // Pointer advance with explicit wrap; capacity need not be a power of two.
   function automatic logic [PW-1:0] wrap_add(input logic [PW-1:0] p, input int unsigned k);
      int unsigned s;
      s = 32'(p) + k;
      if (s >= NUM_PHYS_REGS) s = s - NUM_PHYS_REGS;
      return PW'(s);
   endfunction

   always_comb begin
      for (int unsigned k = 0; k < ALLOC_W; k++) begin
         free_register_data[k] = mem_q[wrap_add(head_q, k)];
      end
   end

   // Recycled lanes then released indices are packed contiguously from the tail.
   always_comb begin
      mem_d       = mem_q;
      head_d      = head_q;
      tail_d      = tail_q;
      count_d     = count_q;
      frl_valid_d = frl_valid_q;
      err_uf_d    = err_uf_q;
      err_of_d    = err_of_q;
      slot        = 0;
      occ         = count_q;
      pop         = frl_valid_q && (|frl_ready);

      if (!frl_valid_q && (|frl_ready)) err_uf_d = 1'b1;

      if (pop) begin
         head_d = wrap_add(head_q, ALLOC_W);
         for (int unsigned k = 0; k < ALLOC_W; k++) begin
            if (frl_ready[k]) begin
               occ = occ - CW'(1);
            end else begin
               mem_d[wrap_add(tail_q, slot)] = free_register_data[k];
               slot = slot + 1;
            end
         end
      end

      // Recycled lanes never change occupancy, so only releases can overflow.
      for (int unsigned p = 0; p < FREE_W; p++) begin
         if (free_valid[p]) begin
            if (occ < CW'(NUM_PHYS_REGS)) begin
               mem_d[wrap_add(tail_q, slot)] = free_idx[p];
               slot = slot + 1;
               occ  = occ + CW'(1);
            end else begin
               err_of_d = 1'b1;
            end
         end
      end

      tail_d      = wrap_add(tail_q, slot);
      count_d     = occ;
      frl_valid_d = (occ >= CW'(ALLOC_W));
   end

   always_ff @(posedge clk) begin
      if (rst_in) begin
         for (int unsigned i = 0; i < NUM_PHYS_REGS; i++) begin
            mem_q[i] <= (i < INIT_CNT) ? PW'(RESERVED + i) : '0;
         end
         head_q      <= '0;
         tail_q      <= INIT_TAIL;
         count_q     <= CW'(INIT_CNT);
         frl_valid_q <= (INIT_CNT >= ALLOC_W);
         err_uf_q    <= 1'b0;
         err_of_q    <= 1'b0;
      end else begin
         mem_q       <= mem_d;
         head_q      <= head_d;
         tail_q      <= tail_d;
         count_q     <= count_d;
         frl_valid_q <= frl_valid_d;
         err_uf_q    <= err_uf_d;
         err_of_q    <= err_of_d;
      end
   end

   assign frl_valid     = frl_valid_q;
   assign free_count    = count_q;
   assign err_underflow = err_uf_q;
   assign err_overflow  = err_of_q;

endmodule

// File: tb/tb_phys_reg_free_list.sv
// Scoreboard bench for phys_reg_free_list (16 regs, 4 alloc lanes, 2 free ports, 4 reserved).
module tb_phys_reg_free_list;

   logic             clk = 1'b0;
   logic             rst_in;
   logic [3:0][3:0]  free_register_data;
   logic             frl_valid;
   logic [3:0]       frl_ready;
   logic [1:0]       free_valid;
   logic [1:0][3:0]  free_idx;
   logic [4:0]       free_count;
   logic             err_underflow;
   logic             err_overflow;

   phys_reg_free_list #(
      .NUM_PHYS_REGS (16),
      .ALLOC_W       (4),
      .FREE_W        (2),
      .RESERVED      (4)
   ) dut (
      .clk                (clk),
      .rst_in             (rst_in),
      .free_register_data (free_register_data),
      .frl_valid          (frl_valid),
      .frl_ready          (frl_ready),
      .free_valid         (free_valid),
      .free_idx           (free_idx),
      .free_count         (free_count),
      .err_underflow      (err_underflow),
      .err_overflow       (err_overflow)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      int              id;
      logic [3:0][3:0] win;
      logic [3:0]      wmask;
      logic            vld;
      logic [4:0]      cnt;
      logic            uf;
      logic            of;
   } exp_t;

   exp_t sbq[$];
   exp_t mon_e;
   int   n_cmp  = 0;
   int   n_fail = 0;
   int   step_id = 0;

   task automatic chk(input string nm, input int id, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL step %0d %s: got %0d expected %0d", id, nm, act, exp);
      end
   endtask

   // Monitor: state after each edge is compared against the oldest queued expectation.
   always @(posedge clk) begin
      #2;
      if (sbq.size() > 0) begin
         mon_e = sbq.pop_front();
         for (int k = 0; k < 4; k++) begin
            if (mon_e.wmask[k])
               chk($sformatf("lane%0d", k), mon_e.id, int'(free_register_data[k]), int'(mon_e.win[k]));
         end
         chk("frl_valid", mon_e.id, int'(frl_valid), int'(mon_e.vld));
         chk("free_count", mon_e.id, int'(free_count), int'(mon_e.cnt));
         chk("err_underflow", mon_e.id, int'(err_underflow), int'(mon_e.uf));
         chk("err_overflow", mon_e.id, int'(err_overflow), int'(mon_e.of));
      end
   end

   task automatic step(input logic r, input logic [3:0] rdy, input logic [1:0] fv,
                       input logic [3:0] i0, input logic [3:0] i1,
                       input logic [3:0] w0, input logic [3:0] w1,
                       input logic [3:0] w2, input logic [3:0] w3,
                       input logic [3:0] wm, input logic vld, input int cnt,
                       input logic uf, input logic of);
      exp_t e;
      @(negedge clk);
      rst_in      = r;
      frl_ready   = rdy;
      free_valid  = fv;
      free_idx[0] = i0;
      free_idx[1] = i1;
      e.id    = step_id;
      e.win   = {w3, w2, w1, w0};
      e.wmask = wm;
      e.vld   = vld;
      e.cnt   = 5'(cnt);
      e.uf    = uf;
      e.of    = of;
      sbq.push_back(e);
      step_id++;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int budget;
      rst_in     = 1'b1;
      frl_ready  = '0;
      free_valid = '0;
      free_idx   = '0;

      // reset state
      step(1, 4'h0, 2'b00, 0, 0,   4, 5, 6, 7,     4'hF, 1, 12, 0, 0);
      // full pop
      step(0, 4'hF, 2'b00, 0, 0,   8, 9, 10, 11,   4'hF, 1, 8, 0, 0);
      step(1, 4'h0, 2'b00, 0, 0,   4, 5, 6, 7,     4'hF, 1, 12, 0, 0);
      // partial consume: p5,p7 recycled to tail
      step(0, 4'h5, 2'b00, 0, 0,   8, 9, 10, 11,   4'hF, 1, 10, 0, 0);
      step(0, 4'hF, 2'b00, 0, 0,   12, 13, 14, 15, 4'hF, 1, 6, 0, 0);
      step(0, 4'hF, 2'b00, 0, 0,   5, 7, 0, 0,     4'h3, 0, 2, 0, 0);
      step(1, 4'h0, 2'b00, 0, 0,   4, 5, 6, 7,     4'hF, 1, 12, 0, 0);
      // drain to empty, then underflow
      step(0, 4'hF, 2'b00, 0, 0,   8, 9, 10, 11,   4'hF, 1, 8, 0, 0);
      step(0, 4'hF, 2'b00, 0, 0,   12, 13, 14, 15, 4'hF, 1, 4, 0, 0);
      step(0, 4'hF, 2'b00, 0, 0,   0, 0, 0, 0,     4'h0, 0, 0, 0, 0);
      step(0, 4'h1, 2'b00, 0, 0,   0, 0, 0, 0,     4'h0, 0, 0, 1, 0);
      step(0, 4'h1, 2'b11, 4, 5,   4, 5, 0, 0,     4'h3, 0, 2, 1, 0);
      step(0, 4'h0, 2'b11, 6, 7,   4, 5, 6, 7,     4'hF, 1, 4, 1, 0);
      // pop at count==ALLOC_W with frees; tail wraps past index 15
      step(0, 4'hF, 2'b11, 4, 5,   4, 5, 0, 0,     4'h3, 0, 2, 1, 0);
      step(0, 4'h0, 2'b11, 6, 7,   4, 5, 6, 7,     4'hF, 1, 4, 1, 0);
      step(0, 4'h3, 2'b11, 8, 9,   6, 7, 8, 9,     4'hF, 1, 4, 1, 0);
      // overflow
      step(1, 4'h0, 2'b00, 0, 0,   4, 5, 6, 7,     4'hF, 1, 12, 0, 0);
      step(0, 4'h0, 2'b11, 0, 1,   4, 5, 6, 7,     4'hF, 1, 14, 0, 0);
      step(0, 4'h0, 2'b01, 2, 0,   4, 5, 6, 7,     4'hF, 1, 15, 0, 0);
      step(0, 4'h0, 2'b11, 3, 8,   4, 5, 6, 7,     4'hF, 1, 16, 0, 1);
      step(0, 4'h0, 2'b11, 9, 10,  4, 5, 6, 7,     4'hF, 1, 16, 0, 1);
      step(0, 4'hF, 2'b11, 10, 11, 8, 9, 10, 11,   4'hF, 1, 14, 0, 1);
      // reset mid-operation discards that cycle's traffic
      step(1, 4'hF, 2'b11, 12, 13, 4, 5, 6, 7,     4'hF, 1, 12, 0, 0);
      step(0, 4'hF, 2'b00, 0, 0,   8, 9, 10, 11,   4'hF, 1, 8, 0, 0);

      @(negedge clk);
      rst_in     = 1'b0;
      frl_ready  = '0;
      free_valid = '0;
      budget = 0;
      while (sbq.size() > 0 && budget < 20) begin
         @(negedge clk);
         budget++;
      end
      if (sbq.size() > 0) begin
         n_cmp++;
         n_fail++;
         $display("FAIL drain: got %0d pending expected 0", sbq.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
